// File: rtl/wb_master_arbiter_if.sv
// Wishbone bundle between two requesting masters, the shared slave and the arbiter.
// The arbiter uses the slave modport; the environment driving both sides uses master.
interface wb_master_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    localparam int SW = DW / 8;

    logic [2*AW-1:0] m_wb_adr_i;
    logic [2*DW-1:0] m_wb_dat_i;
    logic [2*SW-1:0] m_wb_sel_i;
    logic [1:0]      m_wb_we_i;
    logic [1:0]      m_wb_stb_i;
    logic [1:0]      m_wb_cyc_i;
    logic [DW-1:0]   m_wb_dat_o;
    logic [1:0]      m_wb_ack_o;
    logic [1:0]      m_wb_err_o;

    logic [AW-1:0]   s_wb_adr_o;
    logic [DW-1:0]   s_wb_dat_o;
    logic [SW-1:0]   s_wb_sel_o;
    logic            s_wb_we_o;
    logic            s_wb_stb_o;
    logic            s_wb_cyc_o;
    logic [DW-1:0]   s_wb_dat_i;
    logic            s_wb_ack_i;
    logic            s_wb_err_i;

    modport slave (
        input  m_wb_adr_i, m_wb_dat_i, m_wb_sel_i, m_wb_we_i, m_wb_stb_i, m_wb_cyc_i,
        input  s_wb_dat_i, s_wb_ack_i, s_wb_err_i,
        output m_wb_dat_o, m_wb_ack_o, m_wb_err_o,
        output s_wb_adr_o, s_wb_dat_o, s_wb_sel_o, s_wb_we_o, s_wb_stb_o, s_wb_cyc_o
    );

    modport master (
        output m_wb_adr_i, m_wb_dat_i, m_wb_sel_i, m_wb_we_i, m_wb_stb_i, m_wb_cyc_i,
        output s_wb_dat_i, s_wb_ack_i, s_wb_err_i,
        input  m_wb_dat_o, m_wb_ack_o, m_wb_err_o,
        input  s_wb_adr_o, s_wb_dat_o, s_wb_sel_o, s_wb_we_o, s_wb_stb_o, s_wb_cyc_o
    );
endinterface

// File: rtl/wb_master_arbiter.sv
// Two-master round-robin Wishbone arbiter; ownership lasts a whole CYC and a watchdog
// terminates strobes the slave never answers so a hung peripheral cannot lock the bus.
module wb_master_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                i_clk,
    input  logic                i_rst,
    wb_master_arbiter_if.slave  bus,
    output logic [1:0]          o_grant,
    output logic                o_timeout
);
    localparam int SW = DW / 8;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic WD_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CW-1:0] WD_LIMIT = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_last_owner;
    logic          w_last_owner_nxt;
    logic [CW-1:0] r_wd_cnt;
    logic [CW-1:0] w_wd_cnt_nxt;
    logic          r_timeout;

    logic          w_own;
    logic          w_owner;
    logic          w_owner_cyc;
    logic          w_owner_stb;
    logic          w_wait;
    logic          w_wd_fire;

    assign w_own       = (r_state != ST_IDLE);
    assign w_owner     = (r_state == ST_OWN1);
    assign w_owner_cyc = w_own & (w_owner ? bus.m_wb_cyc_i[1] : bus.m_wb_cyc_i[0]);
    assign w_owner_stb = w_own & (w_owner ? bus.m_wb_stb_i[1] : bus.m_wb_stb_i[0]);

    // Slave side follows the owner; the watchdog's terminating cycle forces CYC/STB low.
    assign bus.s_wb_adr_o = w_own ? (w_owner ? bus.m_wb_adr_i[AW +: AW] : bus.m_wb_adr_i[0 +: AW]) : '0;
    assign bus.s_wb_dat_o = w_own ? (w_owner ? bus.m_wb_dat_i[DW +: DW] : bus.m_wb_dat_i[0 +: DW]) : '0;
    assign bus.s_wb_sel_o = w_own ? (w_owner ? bus.m_wb_sel_i[SW +: SW] : bus.m_wb_sel_i[0 +: SW]) : '0;
    assign bus.s_wb_we_o  = w_own & (w_owner ? bus.m_wb_we_i[1] : bus.m_wb_we_i[0]);
    assign bus.s_wb_stb_o = w_owner_stb & ~r_timeout;
    assign bus.s_wb_cyc_o = w_owner_cyc & ~r_timeout;

    assign bus.m_wb_dat_o = bus.s_wb_dat_i;
    assign bus.m_wb_ack_o = {(r_state == ST_OWN1) & bus.s_wb_ack_i,
                             (r_state == ST_OWN0) & bus.s_wb_ack_i};
    assign bus.m_wb_err_o = {(r_state == ST_OWN1) & (bus.s_wb_err_i | r_timeout),
                             (r_state == ST_OWN0) & (bus.s_wb_err_i | r_timeout)};

    assign o_grant   = {r_state == ST_OWN1, r_state == ST_OWN0};
    assign o_timeout = r_timeout;

    // A same-cycle ACK or ERR removes the wait condition, so it always beats the watchdog.
    assign w_wait    = bus.s_wb_stb_o & bus.s_wb_cyc_o & ~bus.s_wb_ack_i & ~bus.s_wb_err_i;
    assign w_wd_fire = WD_EN & w_wait & (r_wd_cnt == WD_LIMIT);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_state_nxt      = r_state;
        w_last_owner_nxt = r_last_owner;
        w_wd_cnt_nxt     = '0;

        if (WD_EN && w_wait && !w_wd_fire) begin
            w_wd_cnt_nxt = r_wd_cnt + 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (bus.m_wb_cyc_i[0] && bus.m_wb_cyc_i[1]) begin
                    w_state_nxt = r_last_owner ? ST_OWN0 : ST_OWN1;
                end else if (bus.m_wb_cyc_i[0]) begin
                    w_state_nxt = ST_OWN0;
                end else if (bus.m_wb_cyc_i[1]) begin
                    w_state_nxt = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!bus.m_wb_cyc_i[0]) begin
                    w_state_nxt      = ST_IDLE;
                    w_last_owner_nxt = 1'b0;
                end
            end
            ST_OWN1: begin
                if (!bus.m_wb_cyc_i[1]) begin
                    w_state_nxt      = ST_IDLE;
                    w_last_owner_nxt = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_last_owner <= 1'b1;
            r_wd_cnt     <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_wd_cnt     <= w_wd_cnt_nxt;
            r_timeout    <= w_wd_fire;
        end
    end
endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter: expected responses are queued as stimulus is driven
// and compared by a monitor whenever the arbiter returns ACK/ERR/timeout to a master.
module tb_wb_master_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    typedef struct {
        logic [1:0]    ack;
        logic [1:0]    err;
        logic          to;
        logic [DW-1:0] dat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] grant;
    logic       timeout;
    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    wb_master_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    wb_master_arbiter #(
        .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus),
        .o_grant(grant),
        .o_timeout(timeout)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_master(input int n, input logic cyc, input logic stb, input logic we,
                              input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        bus.m_wb_cyc_i[n]           = cyc;
        bus.m_wb_stb_i[n]           = stb;
        bus.m_wb_we_i[n]            = we;
        bus.m_wb_adr_i[n*AW +: AW]  = adr;
        bus.m_wb_dat_i[n*DW +: DW]  = dat;
        bus.m_wb_sel_i[n*SW +: SW]  = '1;
    endtask

    function automatic logic [1:0] onehot(input int n);
        return (n == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic exp_t mk(input logic [1:0] ack, input logic [1:0] err, input logic to,
                                input logic [DW-1:0] dat);
        exp_t e;
        e.ack = ack; e.err = err; e.to = to; e.dat = dat;
        return e;
    endfunction

    // Waits (bounded) for the first non-idle grant and requires it to be the expected master.
    task automatic wait_grant(input logic [1:0] exp, input string tag);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (grant == 2'b00 && k < 20);
        check(tag, grant, exp);
        tick();
    endtask

    task automatic beat(input int n, input logic [AW-1:0] adr, input logic [DW-1:0] rdata, input int waits);
        repeat (waits) tick();
        bus.s_wb_ack_i = 1'b1;
        bus.s_wb_dat_i = rdata;
        sb_q.push_back(mk(onehot(n), 2'b00, 1'b0, rdata));
        @(negedge clk);
        check("beat_grant", grant, onehot(n));
        check("beat_adr", bus.s_wb_adr_o, adr);
        tick();
        bus.s_wb_ack_i = 1'b0;
    endtask

    task automatic release_bus(input int n);
        set_master(n, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("release_hold", grant, onehot(n));
        check("release_cyc", bus.s_wb_cyc_o, 1'b0);
        @(negedge clk);
        check("idle_gap", grant, 2'b00);
    endtask

    // Scoreboard monitor: any response to a master must match the oldest queued expectation.
    always @(negedge clk) begin
        if ((bus.m_wb_ack_o | bus.m_wb_err_o) != 2'b00 || timeout) begin
            if (sb_q.size() == 0) begin
                check("unexpected_resp", {bus.m_wb_ack_o, bus.m_wb_err_o, timeout}, 5'b0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("resp_ack", bus.m_wb_ack_o, e.ack);
                check("resp_err", bus.m_wb_err_o, e.err);
                check("resp_timeout", timeout, e.to);
                if (e.ack != 2'b00) check("resp_dat", bus.m_wb_dat_o, e.dat);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench did not terminate");
    end

    initial begin
        logic bad;
        rst = 1'b1;
        bus.m_wb_cyc_i = '0; bus.m_wb_stb_i = '0; bus.m_wb_we_i = '0;
        bus.m_wb_adr_i = '0; bus.m_wb_dat_i = '0; bus.m_wb_sel_i = '0;
        bus.s_wb_ack_i = 1'b0; bus.s_wb_err_i = 1'b0; bus.s_wb_dat_i = 32'hA5A5_0000;

        // Reset state
        tick(); tick();
        @(negedge clk);
        check("rst_grant", grant, 2'b00);
        check("rst_cyc", bus.s_wb_cyc_o, 1'b0);
        check("rst_stb", bus.s_wb_stb_o, 1'b0);
        check("rst_ack_err", {bus.m_wb_ack_o, bus.m_wb_err_o, timeout}, 5'b0);
        check("rst_dat_bcast", bus.m_wb_dat_o, 32'hA5A5_0000);
        tick();
        rst = 1'b0;

        // 1: m0 write, registered grant, slave acks two cycles after STB
        set_master(0, 1'b1, 1'b1, 1'b1, 32'h4000_0010, 32'hDEAD_BEEF);
        @(negedge clk);
        check("t1_grant_delay", grant, 2'b00);
        @(negedge clk);
        check("t1_grant", grant, 2'b01);
        check("t1_cyc_stb_we", {bus.s_wb_cyc_o, bus.s_wb_stb_o, bus.s_wb_we_o}, 3'b111);
        check("t1_adr", bus.s_wb_adr_o, 32'h4000_0010);
        check("t1_dat", bus.s_wb_dat_o, 32'hDEAD_BEEF);
        check("t1_sel", bus.s_wb_sel_o, 4'hF);
        tick(); tick();
        bus.s_wb_ack_i = 1'b1;
        sb_q.push_back(mk(2'b01, 2'b00, 1'b0, 32'hA5A5_0000));
        @(negedge clk);
        check("t1_m1_no_ack", bus.m_wb_ack_o[1], 1'b0);
        tick();
        bus.s_wb_ack_i = 1'b0;
        @(negedge clk);
        check("t1_ack_one_cycle", bus.m_wb_ack_o, 2'b00);
        tick();
        release_bus(0);

        // 2: after reset a tie goes to m0, then m1, and the repeat tie alternates back to m0
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int r = 0; r < 2; r++) begin
            set_master(0, 1'b1, 1'b1, 1'b0, 32'h0000_0004, '0);
            set_master(1, 1'b1, 1'b1, 1'b0, 32'h0000_0004, '0);
            wait_grant(2'b01, "t2_tie_m0");
            beat(0, 32'h0000_0004, 32'hA0 + DW'(r), 0);
            release_bus(0);
            wait_grant(2'b10, "t2_then_m1");
            beat(1, 32'h0000_0004, 32'hB0 + DW'(r), 0);
            release_bus(1);
        end

        // 3: m1 holds CYC over three back-to-back reads while m0 waits
        set_master(1, 1'b1, 1'b1, 1'b0, 32'h0000_0100, '0);
        wait_grant(2'b10, "t3_m1_grant");
        set_master(0, 1'b1, 1'b1, 1'b0, 32'h0000_0200, '0);
        beat(1, 32'h0000_0100, 32'h11, 0);
        set_master(1, 1'b1, 1'b1, 1'b0, 32'h0000_0104, '0);
        beat(1, 32'h0000_0104, 32'h22, 0);
        set_master(1, 1'b1, 1'b1, 1'b0, 32'h0000_0108, '0);
        beat(1, 32'h0000_0108, 32'h33, 0);
        release_bus(1);
        wait_grant(2'b01, "t3_m0_after");
        beat(0, 32'h0000_0200, 32'h44, 1);
        release_bus(0);

        // 4: silent slave -> watchdog error after 16 STB cycles
        set_master(0, 1'b1, 1'b1, 1'b1, 32'h0000_0300, 32'h1234_5678);
        wait_grant(2'b01, "t4_grant");
        set_master(1, 1'b1, 1'b1, 1'b0, 32'h0000_0500, '0);
        sb_q.push_back(mk(2'b00, 2'b01, 1'b1, '0));
        bad = 1'b0;
        for (int i = 0; i < TO - 1; i++) begin
            @(negedge clk);
            if (timeout || !bus.s_wb_stb_o) bad = 1'b1;
        end
        check("t4_no_early_timeout", bad, 1'b0);
        @(negedge clk);
        check("t4_timeout", timeout, 1'b1);
        check("t4_forced_low", {bus.s_wb_cyc_o, bus.s_wb_stb_o}, 2'b00);
        check("t4_still_owner", grant, 2'b01);
        @(negedge clk);
        check("t4_pulse_one", {timeout, bus.m_wb_err_o}, 3'b000);
        check("t4_stb_back", bus.s_wb_stb_o, 1'b1);
        tick();
        release_bus(0);
        wait_grant(2'b10, "t4_m1_grant");
        beat(1, 32'h0000_0500, 32'h55, 0);
        release_bus(1);

        // 5: ACK on the 16th wait cycle wins; later slave ERR passes without timeout
        set_master(0, 1'b1, 1'b1, 1'b0, 32'h0000_0400, '0);
        wait_grant(2'b01, "t5_grant");
        repeat (TO - 2) tick();
        bus.s_wb_ack_i = 1'b1;
        bus.s_wb_dat_i = 32'h66;
        sb_q.push_back(mk(2'b01, 2'b00, 1'b0, 32'h66));
        @(negedge clk);
        check("t5_ack_wins", {timeout, bus.m_wb_err_o}, 3'b000);
        tick();
        bus.s_wb_ack_i = 1'b0;
        @(negedge clk);
        check("t5_no_late_timeout", {timeout, bus.s_wb_stb_o}, 2'b01);
        tick();
        repeat (TO - 2) tick();
        bus.s_wb_err_i = 1'b1;
        sb_q.push_back(mk(2'b00, 2'b01, 1'b0, '0));
        @(negedge clk);
        check("t5_err_no_timeout", timeout, 1'b0);
        tick();
        bus.s_wb_err_i = 1'b0;
        @(negedge clk);
        check("t5_err_clears_wd", timeout, 1'b0);
        tick();
        release_bus(0);

        // ACK and ERR together pass through unchanged to the owner
        set_master(1, 1'b1, 1'b1, 1'b0, 32'h0000_0600, '0);
        wait_grant(2'b10, "t5b_grant");
        bus.s_wb_ack_i = 1'b1;
        bus.s_wb_err_i = 1'b1;
        bus.s_wb_dat_i = 32'h77;
        sb_q.push_back(mk(2'b10, 2'b10, 1'b0, 32'h77));
        tick();
        bus.s_wb_ack_i = 1'b0;
        bus.s_wb_err_i = 1'b0;
        release_bus(1);

        // 6: reset during an m0 wait state aborts silently; afterwards a tie grants m0
        set_master(0, 1'b1, 1'b1, 1'b0, 32'h0000_0700, '0);
        wait_grant(2'b01, "t6_grant");
        set_master(1, 1'b1, 1'b1, 1'b0, 32'h0000_0800, '0);
        rst = 1'b1;
        @(negedge clk);
        check("t6_pre_edge_cyc", bus.s_wb_cyc_o, 1'b1);
        tick();
        @(negedge clk);
        check("t6_rst_cyc_stb", {bus.s_wb_cyc_o, bus.s_wb_stb_o}, 2'b00);
        check("t6_rst_grant", grant, 2'b00);
        check("t6_rst_no_resp", {bus.m_wb_ack_o, bus.m_wb_err_o, timeout}, 5'b0);
        tick();
        rst = 1'b0;
        wait_grant(2'b01, "t6_tie_m0");
        beat(0, 32'h0000_0700, 32'h88, 0);
        release_bus(0);
        wait_grant(2'b10, "t6_then_m1");
        beat(1, 32'h0000_0800, 32'h99, 0);
        release_bus(1);

        repeat (2) tick();
        check("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
